rps_match_scoreboard: RTL and testbench

Match scoreboard that consumes the per-round ASCII result byte produced by the stone-paper-scissors judge and turns individual rounds into a first-to-N match. Tracks per-player wins, ties, rounds played and invalid rounds, and declares the match winner. Sits directly downstream of the judge's registered result output and drives the status display character.

---
 rtl/rps_match_scoreboard.sv | 134 +++++++++++++
 tb/tb_rps_match_scoreboard.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/rps_match_scoreboard.sv
// First-to-N match scoreboard fed by the stone-paper-scissors judge result byte.
// Keeps scores, ties and round counts, declares the winner and drives a status character.
module rps_match_scoreboard #(
  parameter int WINS_TO_MATCH = 3,
  parameter int CNT_W         = 4,
  parameter int ROUND_W       = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic [7:0]         res_code,
  input  logic               res_valid,
  output logic               res_ready,
  input  logic               new_match,
  output logic [CNT_W-1:0]   p1_score,
  output logic [CNT_W-1:0]   p2_score,
  output logic [CNT_W-1:0]   ties,
  output logic [ROUND_W-1:0] round_cnt,
  output logic [1:0]         state,
  output logic               match_over,
  output logic [1:0]         match_winner,
  output logic               err_pulse,
  output logic [7:0]         disp_out
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PLAY = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0]   WIN_LAST  = CNT_W'(WINS_TO_MATCH - 1);
  localparam logic [CNT_W-1:0]   TIES_MAX  = '1;
  localparam logic [ROUND_W-1:0] ROUND_MAX = '1;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   p1_reg, p1_next;
  logic [CNT_W-1:0]   p2_reg, p2_next;
  logic [CNT_W-1:0]   ties_reg, ties_next;
  logic [ROUND_W-1:0] round_reg, round_next;
  logic [1:0]         winner_reg, winner_next;
  logic               err_reg, err_next;
  logic               accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      p1_reg     <= '0;
      p2_reg     <= '0;
      ties_reg   <= '0;
      round_reg  <= '0;
      winner_reg <= 2'b00;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      p1_reg     <= p1_next;
      p2_reg     <= p2_next;
      ties_reg   <= ties_next;
      round_reg  <= round_next;
      winner_reg <= winner_next;
      err_reg    <= err_next;
    end
  end

  // A new_match in the same cycle as a result byte takes priority and drops the byte.
  assign accept = ena && res_valid && (state_reg == PLAY) && !new_match;

  always_comb begin
    state_next  = state_reg;
    p1_next     = p1_reg;
    p2_next     = p2_reg;
    ties_next   = ties_reg;
    round_next  = round_reg;
    winner_next = winner_reg;
    err_next    = 1'b0;

    if (ena && new_match) begin
      state_next  = PLAY;
      p1_next     = '0;
      p2_next     = '0;
      ties_next   = '0;
      round_next  = '0;
      winner_next = 2'b00;
    end else if (accept) begin
      case (res_code)
        8'h31: begin
          p1_next    = p1_reg + 1'b1;
          round_next = (round_reg == ROUND_MAX) ? round_reg : round_reg + 1'b1;
          if (p1_reg == WIN_LAST) begin
            state_next  = DONE;
            winner_next = 2'b01;
          end
        end
        8'h32: begin
          p2_next    = p2_reg + 1'b1;
          round_next = (round_reg == ROUND_MAX) ? round_reg : round_reg + 1'b1;
          if (p2_reg == WIN_LAST) begin
            state_next  = DONE;
            winner_next = 2'b10;
          end
        end
        8'h00: begin
          ties_next  = (ties_reg == TIES_MAX) ? ties_reg : ties_reg + 1'b1;
          round_next = (round_reg == ROUND_MAX) ? round_reg : round_reg + 1'b1;
        end
        default: err_next = 1'b1;
      endcase
    end
  end

  always_comb begin
    disp_out = 8'h2D;
    case (state_reg)
      PLAY: begin
        if (p1_reg > p2_reg)      disp_out = 8'h31;
        else if (p2_reg > p1_reg) disp_out = 8'h32;
        else                      disp_out = 8'h3D;
      end
      DONE:    disp_out = (winner_reg == 2'b01) ? 8'h41 : 8'h42;
      default: disp_out = 8'h2D;
    endcase
  end

  assign state        = state_reg;
  assign res_ready    = (state_reg == PLAY);
  assign match_over   = (state_reg == DONE);
  assign p1_score     = p1_reg;
  assign p2_score     = p2_reg;
  assign ties         = ties_reg;
  assign round_cnt    = round_reg;
  assign match_winner = winner_reg;
  assign err_pulse    = err_reg;

endmodule

// File: tb/tb_rps_match_scoreboard.sv
// Self-checking bench: directed scenarios plus random rounds against a rule-level match model.
module tb_rps_match_scoreboard;

  localparam int WINS = 3;
  localparam int CW   = 4;
  localparam int RW   = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ena = 1'b0;
  logic [7:0]    res_code = 8'h00;
  logic          res_valid = 1'b0;
  logic          new_match = 1'b0;
  logic          res_ready;
  logic [CW-1:0] p1_score, p2_score, ties;
  logic [RW-1:0] round_cnt;
  logic [1:0]    state, match_winner;
  logic          match_over, err_pulse;
  logic [7:0]    disp_out;

  int checks = 0;
  int failures = 0;

  // Reference model: plain integers following the match rules.
  int m_p1, m_p2, m_ties, m_rounds, m_state, m_winner, m_err;

  rps_match_scoreboard #(.WINS_TO_MATCH(WINS), .CNT_W(CW), .ROUND_W(RW)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .res_code(res_code), .res_valid(res_valid),
    .res_ready(res_ready), .new_match(new_match), .p1_score(p1_score), .p2_score(p2_score),
    .ties(ties), .round_cnt(round_cnt), .state(state), .match_over(match_over),
    .match_winner(match_winner), .err_pulse(err_pulse), .disp_out(disp_out)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_p1 = 0; m_p2 = 0; m_ties = 0; m_rounds = 0;
    m_state = 0; m_winner = 0; m_err = 0;
  endtask

  task automatic model_step(input bit e, input bit v, input logic [7:0] c, input bit n);
    m_err = 0;
    if (!e) return;
    if (n) begin
      m_p1 = 0; m_p2 = 0; m_ties = 0; m_rounds = 0; m_winner = 0; m_state = 1;
      return;
    end
    if (!v || m_state != 1) return;
    if (c == 8'h31 || c == 8'h32 || c == 8'h00) begin
      if (m_rounds < (1 << RW) - 1) m_rounds++;
      if (c == 8'h00) begin
        if (m_ties < (1 << CW) - 1) m_ties++;
      end else if (c == 8'h31) begin
        m_p1++;
        if (m_p1 == WINS) begin m_state = 2; m_winner = 1; end
      end else begin
        m_p2++;
        if (m_p2 == WINS) begin m_state = 2; m_winner = 2; end
      end
    end else begin
      m_err = 1;
    end
  endtask

  function automatic logic [7:0] model_disp();
    if (m_state == 0) return 8'h2D;
    if (m_state == 2) return (m_winner == 1) ? 8'h41 : 8'h42;
    if (m_p1 > m_p2) return 8'h31;
    if (m_p2 > m_p1) return 8'h32;
    return 8'h3D;
  endfunction

  // One clock of stimulus; outputs are sampled 1 ns after the edge.
  task automatic cycle(input bit e, input bit v, input logic [7:0] c, input bit n);
    ena = e; res_valid = v; res_code = c; new_match = n;
    @(posedge clk);
    model_step(e, v, c, n);
    #1;
    $display("txn ena=%0b valid=%0b code=%02h new=%0b -> p1=%0d p2=%0d ties=%0d rnd=%0d st=%0d win=%0d err=%0b disp=%02h",
             e, v, c, n, p1_score, p2_score, ties, round_cnt, state, match_winner, err_pulse, disp_out);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    #3;
    checks++; if (state !== 2'b00) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++; if ({p1_score, p2_score, ties, round_cnt} !== '0) begin failures++; $display("FAIL reset_counters got=%0h exp=0", {p1_score, p2_score, ties, round_cnt}); end
    checks++; if ({match_winner, match_over, res_ready, err_pulse} !== 5'b0) begin failures++; $display("FAIL reset_flags got=%05b exp=00000", {match_winner, match_over, res_ready, err_pulse}); end
    checks++; if (disp_out !== 8'h2D) begin failures++; $display("FAIL reset_disp got=%02h exp=2d", disp_out); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycle(1, 1, 8'h31, 0);
    checks++; if (p1_score !== 0 || err_pulse !== 1'b0 || state !== 2'b00) begin failures++; $display("FAIL idle_ignore got p1=%0d err=%0b st=%0d exp 0/0/0", p1_score, err_pulse, state); end
  endtask

  task automatic test_p1_match();
    logic [7:0] seq [5];
    seq = '{8'h31, 8'h00, 8'h32, 8'h31, 8'h31};
    cycle(1, 0, 8'h00, 1);
    checks++; if (state !== 2'b01 || res_ready !== 1'b1 || disp_out !== 8'h3D) begin failures++; $display("FAIL start_play got st=%0d rdy=%0b disp=%02h exp 1/1/3d", state, res_ready, disp_out); end
    foreach (seq[i]) cycle(1, 1, seq[i], 0);
    checks++; if (p1_score !== 3 || p2_score !== 1 || ties !== 1 || round_cnt !== 5) begin failures++; $display("FAIL p1_match_counts got p1=%0d p2=%0d t=%0d r=%0d exp 3/1/1/5", p1_score, p2_score, ties, round_cnt); end
    checks++; if (state !== 2'b10 || match_winner !== 2'b01 || match_over !== 1'b1 || res_ready !== 1'b0) begin failures++; $display("FAIL p1_match_done got st=%0d win=%0d over=%0b rdy=%0b exp 2/1/1/0", state, match_winner, match_over, res_ready); end
    checks++; if (disp_out !== 8'h41) begin failures++; $display("FAIL p1_match_disp got=%02h exp=41", disp_out); end
    cycle(1, 1, 8'h32, 0);
    checks++; if (p2_score !== 1 || round_cnt !== 5 || state !== 2'b10) begin failures++; $display("FAIL done_ignore got p2=%0d r=%0d st=%0d exp 1/5/2", p2_score, round_cnt, state); end
  endtask

  task automatic test_leader_invalid();
    cycle(1, 0, 8'h00, 1);
    cycle(1, 1, 8'h32, 0);
    checks++; if (disp_out !== 8'h32) begin failures++; $display("FAIL leader_disp got=%02h exp=32", disp_out); end
    cycle(1, 1, 8'h3F, 0);
    checks++; if (err_pulse !== 1'b1) begin failures++; $display("FAIL err_first got=%0b exp=1", err_pulse); end
    cycle(1, 1, 8'h55, 0);
    checks++; if (err_pulse !== 1'b1) begin failures++; $display("FAIL err_second got=%0b exp=1", err_pulse); end
    cycle(1, 0, 8'h00, 0);
    checks++; if (err_pulse !== 1'b0) begin failures++; $display("FAIL err_clear got=%0b exp=0", err_pulse); end
    checks++; if (p2_score !== 1 || p1_score !== 0 || ties !== 0 || round_cnt !== 1) begin failures++; $display("FAIL invalid_counts got p1=%0d p2=%0d t=%0d r=%0d exp 0/1/0/1", p1_score, p2_score, ties, round_cnt); end
  endtask

  task automatic test_collision_enable();
    cycle(1, 1, 8'h31, 1);
    checks++; if (p1_score !== 0 || p2_score !== 0 || round_cnt !== 0 || state !== 2'b01) begin failures++; $display("FAIL collision got p1=%0d p2=%0d r=%0d st=%0d exp 0/0/0/1", p1_score, p2_score, round_cnt, state); end
    cycle(0, 1, 8'h32, 0);
    checks++; if (p2_score !== 0 || round_cnt !== 0) begin failures++; $display("FAIL ena_low got p2=%0d r=%0d exp 0/0", p2_score, round_cnt); end
    cycle(1, 1, 8'h3F, 0);
    cycle(0, 0, 8'h00, 0);
    checks++; if (err_pulse !== 1'b0) begin failures++; $display("FAIL err_ena_low got=%0b exp=0", err_pulse); end
  endtask

  task automatic test_saturation();
    cycle(1, 0, 8'h00, 1);
    for (int i = 0; i < 40; i++) cycle(1, 1, 8'h00, 0);
    checks++; if (round_cnt !== 31) begin failures++; $display("FAIL sat_rounds got=%0d exp=31", round_cnt); end
    checks++; if (ties !== 15) begin failures++; $display("FAIL sat_ties got=%0d exp=15", ties); end
    checks++; if (state !== 2'b01 || disp_out !== 8'h3D) begin failures++; $display("FAIL sat_state got st=%0d disp=%02h exp 1/3d", state, disp_out); end
  endtask

  task automatic test_mid_reset();
    logic [7:0] seq [4];
    seq = '{8'h31, 8'h32, 8'h31, 8'h32};
    cycle(1, 0, 8'h00, 1);
    foreach (seq[i]) cycle(1, 1, seq[i], 0);
    checks++; if (p1_score !== 2 || p2_score !== 2 || disp_out !== 8'h3D) begin failures++; $display("FAIL pre_reset got p1=%0d p2=%0d disp=%02h exp 2/2/3d", p1_score, p2_score, disp_out); end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (state !== 2'b00 || {p1_score, p2_score, ties, round_cnt} !== '0 || disp_out !== 8'h2D) begin failures++; $display("FAIL async_reset got st=%0d cnt=%0h disp=%02h exp 0/0/2d", state, {p1_score, p2_score, ties, round_cnt}, disp_out); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycle(1, 1, 8'h31, 0);
    checks++; if (state !== 2'b00 || p1_score !== 0 || res_ready !== 1'b0) begin failures++; $display("FAIL post_reset got st=%0d p1=%0d rdy=%0b exp 0/0/0", state, p1_score, res_ready); end
  endtask

  task automatic test_random();
    logic [7:0] codes [4];
    logic [7:0] c;
    bit e, v, n;
    codes = '{8'h00, 8'h31, 8'h32, 8'h3F};
    for (int i = 0; i < 250; i++) begin
      e = ($urandom_range(0, 9) != 0);
      n = ($urandom_range(0, 24) == 0);
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 9) == 0) ? 8'($urandom) : codes[$urandom_range(0, 3)];
      cycle(e, v, c, n);
      checks++;
      if (p1_score !== m_p1[CW-1:0] || p2_score !== m_p2[CW-1:0] || ties !== m_ties[CW-1:0] || round_cnt !== m_rounds[RW-1:0]) begin
        failures++;
        $display("FAIL rand_counts[%0d] got p1=%0d p2=%0d t=%0d r=%0d exp %0d/%0d/%0d/%0d", i, p1_score, p2_score, ties, round_cnt, m_p1, m_p2, m_ties, m_rounds);
      end
      checks++;
      if (state !== m_state[1:0] || match_winner !== m_winner[1:0] || err_pulse !== m_err[0] || match_over !== (m_state == 2) || res_ready !== (m_state == 1)) begin
        failures++;
        $display("FAIL rand_status[%0d] got st=%0d win=%0d err=%0b over=%0b rdy=%0b exp st=%0d win=%0d err=%0d", i, state, match_winner, err_pulse, match_over, res_ready, m_state, m_winner, m_err);
      end
      checks++;
      if (disp_out !== model_disp()) begin
        failures++;
        $display("FAIL rand_disp[%0d] got=%02h exp=%02h", i, disp_out, model_disp());
      end
    end
  endtask

  initial begin
    test_reset();
    test_p1_match();
    test_leader_invalid();
    test_collision_enable();
    test_saturation();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
